// File: rtl/seg_disp_arbiter.sv
// seg_disp_arbiter: round-robin owner selection for the shared 8-digit
// seven-segment display. A granted owner keeps the display for at least
// HOLD_CYCLES clocks; the owner may refresh its word during that window.
module seg_disp_arbiter #(
   parameter int unsigned HOLD_CYCLES = 50_000_000,
   parameter int unsigned HOLD_W      = 26
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  req,
   input  logic [31:0] data0,
   input  logic [31:0] data1,
   input  logic [31:0] data2,
   output logic [2:0]  ack,
   output logic [31:0] disp_data,
   output logic [1:0]  disp_src,
   output logic        busy
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t            state;
   logic [HOLD_W-1:0] cnt;
   logic [1:0]        last;

   logic [2:0]  eff_req;
   logic [1:0]  grant_idx;
   logic        grant_vld;
   logic [31:0] grant_word;
   logic [2:0]  own_onehot;
   logic        own_req;
   logic [31:0] own_word;
   logic        hold_done;

   // A source is ignored in its own ack cycle so one request is never granted twice
   always_comb begin
      eff_req    = req & ~ack;
      grant_vld  = |eff_req;
      own_onehot = 3'b001 << disp_src;
      own_req    = |(eff_req & own_onehot);
      hold_done  = (cnt == HOLD_W'(HOLD_CYCLES - 1));
   end

   // Round-robin pick: scan sources starting just after the last winner
   always_comb begin
      grant_idx = '0;
      case (last)
         2'd0: begin
            if (eff_req[1])      grant_idx = 2'd1;
            else if (eff_req[2]) grant_idx = 2'd2;
            else                 grant_idx = 2'd0;
         end
         2'd1: begin
            if (eff_req[2])      grant_idx = 2'd2;
            else if (eff_req[0]) grant_idx = 2'd0;
            else                 grant_idx = 2'd1;
         end
         default: begin
            if (eff_req[0])      grant_idx = 2'd0;
            else if (eff_req[1]) grant_idx = 2'd1;
            else                 grant_idx = 2'd2;
         end
      endcase
   end

   // Word of the round-robin winner
   always_comb begin
      grant_word = '0;
      case (grant_idx)
         2'd0:    grant_word = data0;
         2'd1:    grant_word = data1;
         default: grant_word = data2;
      endcase
   end

   // Word of the current owner, used for refresh during the hold window
   always_comb begin
      own_word = '0;
      case (disp_src)
         2'd0:    own_word = data0;
         2'd1:    own_word = data1;
         default: own_word = data2;
      endcase
   end

   // Arbitration FSM with registered display, ack and busy outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         last      <= 2'd2;
         ack       <= '0;
         disp_data <= '0;
         disp_src  <= '0;
         busy      <= 1'b0;
      end else begin
         ack <= '0;
         case (state)
            IDLE: begin
               if (grant_vld) begin
                  disp_data <= grant_word;
                  disp_src  <= grant_idx;
                  ack       <= 3'b001 << grant_idx;
                  last      <= grant_idx;
                  cnt       <= '0;
                  busy      <= 1'b1;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               // refresh does not restart the window; expiry still applies this cycle
               if (own_req) begin
                  disp_data <= own_word;
                  ack       <= own_onehot;
               end
               if (hold_done) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Testbench for seg_disp_arbiter: directed scenarios followed by random
// requesters, checked against a transaction-level reference model.
module tb_seg_disp_arbiter;

   localparam int H = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req;
   logic [31:0] data [3];
   logic [2:0]  ack;
   logic [31:0] disp_data;
   logic [1:0]  disp_src;
   logic        busy;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   seg_disp_arbiter #(.HOLD_CYCLES(H), .HOLD_W(4)) dut (
      .clk(clk), .rst(rst), .req(req),
      .data0(data[0]), .data1(data[1]), .data2(data[2]),
      .ack(ack), .disp_data(disp_data), .disp_src(disp_src), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  ack;
      logic [1:0]  src;
      logic [31:0] data;
   } tr_t;
   tr_t exp_q[$];

   // Reference model: owner, remaining hold time and last winner as plain integers
   bit          m_hold = 1'b0;
   int          m_left = 0;
   int          m_last = 2;
   int          m_src  = 0;
   logic [31:0] m_data = '0;
   logic [2:0]  m_ack  = '0;

   always @(posedge clk) begin : model
      logic [2:0] eff;
      logic [2:0] nack;
      tr_t t;
      nack = '0;
      if (rst) begin
         m_hold = 1'b0; m_left = 0; m_last = 2; m_src = 0; m_data = '0;
      end else begin
         eff = req & ~m_ack;
         if (!m_hold) begin
            for (int k = 1; k <= 3; k++) begin
               int g;
               g = (m_last + k) % 3;
               if (eff[g] && nack == 3'b000) begin
                  nack[g] = 1'b1;
                  m_src = g; m_data = data[g]; m_last = g;
                  m_hold = 1'b1; m_left = H;
               end
            end
         end else begin
            if (eff[m_src]) begin
               nack[m_src] = 1'b1;
               m_data = data[m_src];
            end
            m_left = m_left - 1;
            if (m_left == 0) m_hold = 1'b0;
         end
      end
      m_ack = nack;
      if (nack != 3'b000) begin
         t.ack = nack; t.src = 2'(m_src); t.data = m_data;
         exp_q.push_back(t);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: per-cycle display state plus ack transactions popped from the scoreboard
   always @(negedge clk) begin
      tr_t t;
      if (mon_en) begin
         chk("busy", 32'(busy), 32'(m_hold));
         chk("disp_src", 32'(disp_src), 32'(m_src));
         chk("disp_data", disp_data, m_data);
         if (ack !== 3'b000) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_ack", 32'(ack), 32'h0);
            end else begin
               t = exp_q.pop_front();
               chk("ack", 32'(ack), 32'(t.ack));
               chk("ack_src", 32'(disp_src), 32'(t.src));
               chk("ack_data", disp_data, t.data);
            end
         end else if (exp_q.size() != 0) begin
            t = exp_q.pop_front();
            chk("missing_ack", 32'(ack), 32'(t.ack));
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Raise req[i] and drop it after its ack, giving up after a bounded wait
   task automatic request(input int i, input logic [31:0] w, input int limit);
      int n;
      data[i] = w;
      req[i] = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ack[i] !== 1'b1 && n < limit);
      chk("req_timeout", 32'(ack[i]), 32'h1);
      req[i] = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      req = '0;
      for (int i = 0; i < 3; i++) data[i] = $urandom;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_data", disp_data, 32'h0);
      chk("rst_src", 32'(disp_src), 32'h0);
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      mon_en = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      // all three sources requesting continuously
      req = 3'b111;
      cyc(30);
      req = '0;
      cyc(8);

      // single request with a known word
      request(0, 32'h1234_5678, 4);
      chk("t2_data", disp_data, 32'h1234_5678);
      chk("t2_busy", 32'(busy), 32'h1);
      // owner refresh inside the window
      cyc(1);
      request(0, 32'hDEAD_BEEF, 4);
      chk("t3_data", disp_data, 32'hDEAD_BEEF);
      cyc(8);

      // competing request withdrawn before the window ends
      request(0, 32'hCAFE_0001, 4);
      data[1] = 32'h1111_1111;
      req[1] = 1'b1;
      cyc(1);
      req[1] = 1'b0;
      cyc(8);
      chk("t4_data", disp_data, 32'hCAFE_0001);

      // reset in the middle of a hold with another source pending
      request(0, 32'hCAFE_0002, 4);
      data[2] = 32'h2222_2222;
      req[2] = 1'b1;
      cyc(1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("t5_data", disp_data, 32'h0);
      chk("t5_busy", 32'(busy), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("t5_ack2", 32'(ack), 32'h4);
      @(negedge clk);
      req[2] = 1'b0;
      cyc(8);

      // random requesters: drop on ack (sometimes keep), withdraw, change data
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 3; i++) begin
            if (req[i] && ack[i] === 1'b1) begin
               if ($urandom_range(3) != 0) req[i] = 1'b0;
            end else if (req[i]) begin
               if ($urandom_range(39) == 0) req[i] = 1'b0;
            end else if ($urandom_range(5) == 0) begin
               data[i] = $urandom;
               req[i] = 1'b1;
            end
            if ($urandom_range(7) == 0) data[i] = $urandom;
         end
         rst = ($urandom_range(499) == 0);
         @(negedge clk);
      end
      rst = 1'b0;
      req = '0;
      cyc(10);
      chk("queue_empty", 32'(exp_q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
